// File: rtl/hex_display_scanner_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hex_display_scanner_pkg
// Description : Shared types and constants for the multiplexed hex display
//               scanner: scan state encoding, digit-entry field layout and
//               the "all dark" output values.
// Revision    : 1.0 - initial release
// ============================================================================
package hex_display_scanner_pkg;

    // Scan phase: one dark gap cycle, then the digit is shown for the rest
    // of its dwell.
    typedef enum logic [0:0] {
        GAP  = 1'b0,
        SHOW = 1'b1
    } scan_state_t;

    // One digit entry is {blank, nibble[3:0]}.
    localparam int ENTRY_W   = 5;
    localparam int BLANK_BIT = 4;
    localparam int NIB_MSB   = 3;
    localparam int NIB_LSB   = 0;

    // Widest supported display; SEL_NONE is sliced down to the real width.
    localparam int MAX_DIGITS = 8;

    localparam logic [6:0]            SEG_OFF     = 7'b0;
    localparam logic [MAX_DIGITS-1:0] SEL_NONE    = '1;
    localparam logic [ENTRY_W-1:0]    ENTRY_RESET = 5'b1_0000;

endpackage : hex_display_scanner_pkg
`default_nettype wire

// File: rtl/hex_display_scanner_hex_decoder.sv
`default_nettype none
// ============================================================================
// Module      : hex_decoder
// Description : Hex nibble to 7-segment pattern, active-high segments,
//               bit order {g,f,e,d,c,b,a} on seg[6:0].
// Revision    : 1.0 - initial release
// ============================================================================
module hex_decoder (
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    // Segment lookup for 0-9, A-F.
    always_comb begin
        seg = 7'h00;
        case (nibble)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            4'hF: seg = 7'h71;
        endcase
    end

endmodule : hex_decoder
`default_nettype wire

// File: rtl/hex_display_scanner.sv
`default_nettype none
// ============================================================================
// Module      : hex_display_scanner
// Description : Time-multiplexed DIGITS-wide 7-segment controller with a
//               shadow/active double bank, frame-aligned commit and a dark
//               gap cycle between digits. All outputs are registered.
// Revision    : 1.0 - initial release
// ============================================================================
module hex_display_scanner
    import hex_display_scanner_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                      CLOCK_50,
    input  logic                      RESET,
    input  logic                      WR_EN,
    input  logic [$clog2(DIGITS)-1:0] WR_ADDR,
    input  logic [ENTRY_W-1:0]        WR_DATA,
    input  logic                      COMMIT,
    output logic                      COMMIT_DONE,
    output logic                      PENDING,
    output logic [6:0]                HEX_SEG,
    output logic [DIGITS-1:0]         DIGIT_SEL
);

    localparam int IDX_W  = $clog2(DIGITS);
    localparam int CNT_W  = $clog2(REFRESH_DIV);
    localparam int BANK_W = DIGITS * ENTRY_W;

    localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(DIGITS - 1);
    localparam logic [BANK_W-1:0] BANK_RESET = {DIGITS{ENTRY_RESET}};
    localparam logic [DIGITS-1:0] SEL_DARK   = SEL_NONE[DIGITS-1:0];

    scan_state_t       r_state;
    scan_state_t       w_state_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_next;
    logic [IDX_W-1:0]  r_idx;
    logic [IDX_W-1:0]  w_idx_next;

    logic [BANK_W-1:0]  r_shadow;
    logic [BANK_W-1:0]  r_active;
    logic [BANK_W-1:0]  w_active_next;
    logic               w_copy;
    logic [ENTRY_W-1:0] w_entry;
    logic [6:0]         w_dec_seg;
    logic [6:0]         w_seg_next;
    logic [DIGITS-1:0]  w_sel_next;
    logic [DIGITS-1:0]  w_onehot;

    // Scan position register: dwell counter, digit index and phase.
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            r_state <= GAP;
            r_cnt   <= '0;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_idx   <= w_idx_next;
        end
    end

    // Next scan position with explicit wraps so odd parameters still work.
    always_comb begin
        w_cnt_next = r_cnt + 1'b1;
        w_idx_next = r_idx;
        if (r_cnt == CNT_LAST) begin
            w_cnt_next = '0;
            w_idx_next = (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
        end
        w_state_next = (w_cnt_next == '0) ? GAP : SHOW;
    end

    // The copy fires at the end of the idx-0 gap cycle; the display for the
    // following cycle must already see the freshly copied bank.
    assign w_copy        = (r_state == GAP) && (r_idx == '0) && PENDING;
    assign w_active_next = w_copy ? r_shadow : r_active;
    assign w_entry       = w_active_next[w_idx_next*ENTRY_W +: ENTRY_W];

    hex_decoder u_hex_decoder (
        .nibble (w_entry[NIB_MSB:NIB_LSB]),
        .seg    (w_dec_seg)
    );

    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_sel
        assign w_onehot[gi] = (w_idx_next == IDX_W'(gi));
    end

    // Output values for the upcoming cycle: dark in the gap, else the digit.
    always_comb begin
        w_seg_next = SEG_OFF;
        w_sel_next = SEL_DARK;
        if (w_state_next == SHOW) begin
            w_sel_next = ~w_onehot;
            w_seg_next = w_entry[BLANK_BIT] ? SEG_OFF : w_dec_seg;
        end
    end

    // Shadow and active banks; a same-cycle write lands after the copy reads.
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            r_shadow <= BANK_RESET;
            r_active <= BANK_RESET;
        end else begin
            r_active <= w_active_next;
            for (int i = 0; i < DIGITS; i++) begin
                if (WR_EN && (WR_ADDR == IDX_W'(i))) begin
                    r_shadow[i*ENTRY_W +: ENTRY_W] <= WR_DATA;
                end
            end
        end
    end

    // Commit handshake: a new request always wins over the clear.
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            PENDING     <= 1'b0;
            COMMIT_DONE <= 1'b0;
        end else begin
            PENDING     <= COMMIT | (PENDING & ~w_copy);
            COMMIT_DONE <= w_copy;
        end
    end

    // Registered segment and anode drivers, updated on the same edge.
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            HEX_SEG   <= SEG_OFF;
            DIGIT_SEL <= SEL_DARK;
        end else begin
            HEX_SEG   <= w_seg_next;
            DIGIT_SEL <= w_sel_next;
        end
    end

endmodule : hex_display_scanner
`default_nettype wire

// File: tb/tb_hex_display_scanner.sv
`default_nettype none
// ============================================================================
// Module      : tb_hex_display_scanner
// Description : Scoreboard bench for hex_display_scanner (DIGITS=4,
//               REFRESH_DIV=4). Cycle k after reset release has cnt=k%4,
//               idx=(k/4)%4; digit d of frame f is first lit in cycle
//               16f+4d+1.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hex_display_scanner;

    localparam int DIGITS      = 4;
    localparam int REFRESH_DIV = 4;

    logic       clk     = 1'b0;
    logic       rst     = 1'b1;
    logic       wr_en   = 1'b0;
    logic [1:0] wr_addr = 2'd0;
    logic [4:0] wr_data = 5'd0;
    logic       commit  = 1'b0;
    logic       commit_done;
    logic       pending;
    logic [6:0] hex_seg;
    logic [3:0] digit_sel;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int         cyc;
        logic [3:0] sel;
        logic [6:0] seg;
    } disp_t;

    typedef struct {
        int   cyc;
        logic val;
    } lvl_t;

    disp_t disp_q[$];
    lvl_t  lvl_q[$];
    int    done_q[$];
    logic  prev_dark = 1'b1;

    hex_display_scanner #(
        .DIGITS      (DIGITS),
        .REFRESH_DIV (REFRESH_DIV)
    ) dut (
        .CLOCK_50    (clk),
        .RESET       (rst),
        .WR_EN       (wr_en),
        .WR_ADDR     (wr_addr),
        .WR_DATA     (wr_data),
        .COMMIT      (commit),
        .COMMIT_DONE (commit_done),
        .PENDING     (pending),
        .HEX_SEG     (hex_seg),
        .DIGIT_SEL   (digit_sel)
    );

    always #5 clk = ~clk;

    // Cycle index since the last reset release.
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic push_frame(input int f, input logic [6:0] s0, input logic [6:0] s1,
                              input logic [6:0] s2, input logic [6:0] s3);
        logic [6:0] segs [4];
        disp_t      e;
        logic [3:0] m;
        segs[0] = s0; segs[1] = s1; segs[2] = s2; segs[3] = s3;
        for (int d = 0; d < 4; d++) begin
            m     = 4'b0001 << d;
            e.cyc = 16 * f + 4 * d + 1;
            e.sel = ~m;
            e.seg = segs[d];
            disp_q.push_back(e);
        end
    endtask

    task automatic push_lvl(input int c, input logic v);
        lvl_t l;
        l.cyc = c;
        l.val = v;
        lvl_q.push_back(l);
    endtask

    task automatic to_cycle(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic do_write(input int c, input logic [1:0] a, input logic [4:0] d);
        to_cycle(c);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic pulse_commit(input int c);
        to_cycle(c);
        commit = 1'b1;
        @(negedge clk);
        commit = 1'b0;
    endtask

    // Monitor: gap darkness, digit presentation, PENDING samples, COMMIT_DONE.
    always @(negedge clk) begin : monitor
        disp_t e;
        lvl_t  l;
        int    dc;
        if (!rst) begin
            if (cyc % 4 == 0) begin
                chk("gap_sel", 16'(digit_sel), 16'h000F);
                chk("gap_seg", 16'(hex_seg), 16'h0000);
            end
            while (disp_q.size() > 0 && disp_q[0].cyc < cyc) begin
                e = disp_q.pop_front();
                checks++;
                errors++;
                $display("FAIL disp_missing: no digit start at cycle %0d (required sel %b seg %h)",
                         e.cyc, e.sel, e.seg);
            end
            if (prev_dark && digit_sel !== 4'hF && disp_q.size() > 0 && disp_q[0].cyc == cyc) begin
                e = disp_q.pop_front();
                chk("disp_sel", 16'(digit_sel), 16'(e.sel));
                chk("disp_seg", 16'(hex_seg), 16'(e.seg));
            end
            if (lvl_q.size() > 0 && lvl_q[0].cyc == cyc) begin
                l = lvl_q.pop_front();
                chk("pending", 16'(pending), 16'(l.val));
            end
            if (commit_done === 1'b1) begin
                if (done_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL done_unexpected: COMMIT_DONE=1 at cycle %0d, required 0", cyc);
                end else begin
                    dc = done_q.pop_front();
                    chk("done_cycle", 16'(cyc), 16'(dc));
                end
            end else if (done_q.size() > 0 && done_q[0] < cyc) begin
                dc = done_q.pop_front();
                checks++;
                errors++;
                $display("FAIL done_missing: COMMIT_DONE=0 at cycle %0d, required 1", dc);
            end
        end
        prev_dark = (digit_sel === 4'hF);
    end

    initial begin : watchdog
        #100000;
        $display("FAIL timeout: bench did not finish, checks %0d", checks);
        $fatal(1);
    end

    initial begin : stimulus
        // Reset state.
        repeat (3) @(negedge clk);
        chk("rst_sel",  16'(digit_sel),   16'h000F);
        chk("rst_seg",  16'(hex_seg),     16'h0000);
        chk("rst_pend", 16'(pending),     16'h0000);
        chk("rst_done", 16'(commit_done), 16'h0000);

        // Idle frames: every digit blank.
        push_frame(0, 7'h00, 7'h00, 7'h00, 7'h00);
        push_frame(1, 7'h00, 7'h00, 7'h00, 7'h00);
        push_frame(2, 7'h00, 7'h00, 7'h00, 7'h00);
        push_lvl(20, 1'b0);
        #1 rst = 1'b0;

        // Write {0,1,A,F}, commit in cycle 36 -> copy at boundary 48.
        to_cycle(32);
        push_frame(3, 7'h3F, 7'h06, 7'h77, 7'h71);
        push_frame(4, 7'h3F, 7'h06, 7'h77, 7'h71);
        push_frame(5, 7'h3F, 7'h06, 7'h77, 7'h71);
        push_frame(6, 7'h3F, 7'h06, 7'h77, 7'h71);
        push_lvl(36, 1'b0);
        push_lvl(37, 1'b1);
        push_lvl(48, 1'b1);
        push_lvl(49, 1'b0);
        done_q.push_back(49);
        do_write(32, 2'd0, 5'h00);
        do_write(33, 2'd1, 5'h01);
        do_write(34, 2'd2, 5'h0A);
        do_write(35, 2'd3, 5'h0F);
        pulse_commit(36);

        // Write without commit: frames 4..6 unchanged; commit just before boundary 112.
        do_write(64, 2'd1, 5'h05);
        push_lvl(111, 1'b0);
        push_lvl(112, 1'b1);
        push_lvl(113, 1'b0);
        done_q.push_back(113);
        push_frame(7, 7'h3F, 7'h6D, 7'h77, 7'h71);
        pulse_commit(111);

        // Write to digit 2 in the copy cycle 128: copy sees old shadow (3).
        do_write(118, 2'd2, 5'h03);
        push_lvl(121, 1'b1);
        push_lvl(128, 1'b1);
        done_q.push_back(129);
        push_frame(8, 7'h3F, 7'h6D, 7'h4F, 7'h71);
        pulse_commit(120);
        do_write(128, 2'd2, 5'h0C);
        done_q.push_back(145);
        push_frame(9,  7'h3F, 7'h6D, 7'h39, 7'h71);
        push_frame(10, 7'h3F, 7'h6D, 7'h39, 7'h71);
        pulse_commit(140);

        // Three commits in one frame -> one COMMIT_DONE; blank digit 3.
        do_write(160, 2'd3, 5'h1F);
        push_lvl(162, 1'b1);
        push_lvl(176, 1'b1);
        push_lvl(177, 1'b0);
        push_lvl(180, 1'b0);
        done_q.push_back(177);
        push_frame(11, 7'h3F, 7'h6D, 7'h39, 7'h00);
        pulse_commit(161);
        pulse_commit(165);
        pulse_commit(170);

        // Commit on a boundary waits a full frame; commit in the copy cycle re-arms.
        push_lvl(192, 1'b0);
        push_lvl(193, 1'b1);
        push_lvl(208, 1'b1);
        push_lvl(209, 1'b1);
        push_lvl(213, 1'b1);
        done_q.push_back(209);
        pulse_commit(192);
        pulse_commit(208);

        // Asynchronous reset mid-SHOW with a pending commit.
        to_cycle(214);
        #2 rst = 1'b1;
        #1;
        chk("arst_sel",  16'(digit_sel),   16'h000F);
        chk("arst_seg",  16'(hex_seg),     16'h0000);
        chk("arst_pend", 16'(pending),     16'h0000);
        chk("arst_done", 16'(commit_done), 16'h0000);
        push_frame(0, 7'h00, 7'h00, 7'h00, 7'h00);
        push_frame(1, 7'h00, 7'h00, 7'h00, 7'h00);
        push_lvl(1, 1'b0);
        push_lvl(20, 1'b0);
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        to_cycle(40);

        chk("disp_q_drained", 16'(disp_q.size()), 16'h0000);
        chk("lvl_q_drained",  16'(lvl_q.size()),  16'h0000);
        chk("done_q_drained", 16'(done_q.size()), 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_hex_display_scanner
`default_nettype wire

// File: doc/hex_display_scanner.md
# hex_display_scanner

- Time-multiplexed controller for a DIGITS-wide common-segment 7-segment display.
- Holds per-digit nibbles and blank bits in a shadow bank. A COMMIT request copies the shadow bank into the active bank at the next frame boundary.
- Scans the active digits one at a time through a single shared hex_decoder instance, with a one-cycle dark gap between digits to suppress ghosting.
- Sits between user logic (counters, switch readers) and the board's segment/anode pins.

## Interface
- DIGITS, 4: number of scanned digits, 2..8.
- REFRESH_DIV, 50000: clock cycles per digit dwell, including the gap cycle; minimum 2.
- CLOCK_50  in  1  system clock, all logic on rising edge.
- RESET  in  1  asynchronous, active-high reset.
- WR_EN  in  1  write strobe, one digit per cycle.
- WR_ADDR  in  $clog2(DIGITS)  shadow digit index; writes with out-of-range addresses are ignored.
- WR_DATA  in  5  [4] blank (1 = digit dark), [3:0] hex nibble.
- COMMIT  in  1  request to copy shadow to active at the next frame boundary.
- COMMIT_DONE  out  1  one-cycle pulse in the cycle the copy occurs.
- PENDING  out  1  high from COMMIT acceptance until the copy.
- HEX_SEG  out  7  segments, active-high (1 = lit), bit order as hex_decoder.
- DIGIT_SEL  out  DIGITS  active-low one-hot digit enable.

## Operation
- State machine: GAP, SHOW.
  - GAP lasts 1 cycle. DIGIT_SEL is all ones and HEX_SEG is 0.
  - SHOW lasts REFRESH_DIV-1 cycles. DIGIT_SEL[idx] is 0. HEX_SEG is decode(active[idx]), or 0 if active blank[idx]=1.
- Dwell counter cnt counts 0..REFRESH_DIV-1.
  - cnt=0 is GAP.
  - At cnt=REFRESH_DIV-1, cnt wraps to 0 and idx advances. idx=DIGITS-1 wraps to 0.
- Frame boundary is the GAP cycle with idx=0 (the gap after a wrap).
- Writes: WR_EN updates shadow[WR_ADDR] at the clock edge. The active bank is never written directly.
- Commit:
  - COMMIT sets PENDING.
  - At a frame boundary with PENDING=1: active ← shadow, PENDING clears, and COMMIT_DONE pulses for that cycle.
  - COMMIT while PENDING=1 has no additional effect.
  - COMMIT in the same cycle as a copy starts a new pending request.
- Simultaneous events:
  - A write and a copy in the same cycle: the copy takes the pre-write shadow value, and the write lands in shadow.
  - COMMIT asserted in the frame-boundary cycle does not copy in that cycle (PENDING must already be 1).
- Reset values:
  - shadow and active: all entries {blank=1, nibble=0}.
  - idx=0, cnt=0, state GAP.
  - DIGIT_SEL all ones, HEX_SEG=0, PENDING=0, COMMIT_DONE=0.
- Reset mid-frame or mid-commit aborts immediately. A pending commit is lost.

## Timing
- All outputs are registered. No combinational path from any input to any output.
- HEX_SEG and DIGIT_SEL change on the same edge. The segment value for idx is registered in the same cycle DIGIT_SEL[idx] falls.
- First SHOW after reset release begins on cycle 1 (cnt=1). It shows digit 0 blanked.
- Frame period: DIGITS×REFRESH_DIV cycles.
- Worst-case commit latency from the COMMIT edge to COMMIT_DONE: DIGITS×REFRESH_DIV cycles. Best case: 1 cycle, when COMMIT is sampled in the cycle before the frame boundary.
- Width rules:
  - cnt width is $clog2(REFRESH_DIV).
  - idx width is $clog2(DIGITS).
  - Wrap comparisons are explicit. No reliance on natural overflow, so non-power-of-two parameters work.

## Structure
- A shared package holds:
  - the scan state encoding (GAP, SHOW);
  - the digit-entry field positions (BLANK_BIT=4, nibble [3:0]);
  - the constants SEG_OFF=7'b0 and SEL_NONE (all ones).
- One sub-module: the existing hex_decoder, instantiated once and fed by the active bank mux output. No decode logic is duplicated.
- Shadow and active banks are flat registers (DIGITS×5 bits), not inferred RAM, so the whole bank is copied in one cycle.

## Test plan
All tests use DIGITS=4, REFRESH_DIV=4.
- Reset then idle 32 cycles: DIGIT_SEL cycles 1110→1101→1011→0111 with 1111 at every cnt=0. HEX_SEG=0 throughout (all blank).
- Write digits 0..3 = {0,1,A,F} unblanked, COMMIT: PENDING high until the next frame boundary. COMMIT_DONE pulses once. Next frame HEX_SEG = 0x3F, 0x06, 0x77, 0x71 (bit 6..0) on the respective selects.
- Write without COMMIT: display unchanged for 3 frames. COMMIT then updates it at exactly the next boundary.
- WR_EN to digit 2 in the same cycle as the copy: active[2] gets the old shadow value; the new value appears only after a second COMMIT.
- COMMIT pulsed 3 times within one frame: exactly one COMMIT_DONE. PENDING low afterwards.
- RESET asserted mid-SHOW with PENDING=1: DIGIT_SEL=1111, HEX_SEG=0, PENDING=0 asynchronously. After release, no COMMIT_DONE occurs.
